// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier datapath (32x32 signed, 16 iterations).
// The Booth control decoder lives outside this block: each RUN cycle the
// current window is sent out and the returned shift/add/sub controls are
// applied to the high accumulator before the 2-bit arithmetic shift.
module booth_mult_seq (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [2:0]  booth_window,
  input  logic        booth_shift,
  input  logic        booth_add,
  input  logic        booth_sub,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] m_q, m_d;
  logic [33:0] hi_q, hi_d;
  logic [32:0] lo_q, lo_d;
  logic [3:0]  count_q, count_d;
  logic        illegal_q, illegal_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;

  logic [33:0] partial_s;
  logic [33:0] sum_s;
  logic        illegal_now_s;
  logic [66:0] shifted_s;
  logic [63:0] product_s;

  // True when the 64-bit product cannot be represented in 32 signed bits.
  function automatic logic overflow_32(input logic [63:0] p);
    return (p[63:32] != {32{p[31]}});
  endfunction

  // Window is only meaningful in RUN; elsewhere the decoder sees a no-op.
  assign booth_window   = (state_q == RUN) ? lo_q[2:0] : 3'b000;
  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

  // One Booth iteration: select M or 2M, add/sub, then shift {hi,lo} right by 2.
  always_comb begin
    partial_s     = booth_shift ? {m_q[31], m_q, 1'b0} : {{2{m_q[31]}}, m_q};
    illegal_now_s = booth_add & booth_sub;
    if (illegal_now_s) begin
      sum_s = hi_q;
    end else if (booth_add) begin
      sum_s = hi_q + partial_s;
    end else if (booth_sub) begin
      sum_s = hi_q - partial_s;
    end else begin
      sum_s = hi_q;
    end
    shifted_s = {{2{sum_s[33]}}, sum_s, lo_q[32:2]};
    product_s = {shifted_s[64:33], shifted_s[32:1]};
  end

  // Next-state and next-datapath selection for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    count_d   = count_q;
    illegal_d = illegal_q;
    result_d  = result_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_MULT) begin
          m_d       = data_operandA;
          hi_d      = 34'd0;
          lo_d      = {data_operandB, 1'b0};
          count_d   = 4'd0;
          illegal_d = 1'b0;
          result_d  = 32'd0;
          exc_d     = 1'b0;
          state_d   = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        hi_d      = shifted_s[66:33];
        lo_d      = shifted_s[32:0];
        count_d   = count_q + 4'd1;
        illegal_d = illegal_q | illegal_now_s;
        if (count_q == 4'd15) begin
          // Results are captured on the same edge that enters DONE.
          result_d = product_s[31:0];
          exc_d    = overflow_32(product_s) | illegal_q | illegal_now_s;
          rdy_d    = 1'b1;
          state_d  = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        count_d = 4'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      m_q       <= 32'd0;
      hi_q      <= 34'd0;
      lo_q      <= 33'd0;
      count_q   <= 4'd0;
      illegal_q <= 1'b0;
      result_q  <= 32'd0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq with a behavioural
// Booth control decoder attached to the window/control ports.
module tb_booth_mult_seq;

  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [2:0]  booth_window;
  logic        booth_shift;
  logic        booth_add;
  logic        booth_sub;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        force_illegal;

  int n_checks = 0;
  int n_errors = 0;

  booth_mult_seq dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .booth_window   (booth_window),
    .booth_shift    (booth_shift),
    .booth_add      (booth_add),
    .booth_sub      (booth_sub),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference Booth decoder, with an override that drives add and sub together.
  always_comb begin
    booth_shift = 1'b0;
    booth_add   = 1'b0;
    booth_sub   = 1'b0;
    case (booth_window)
      3'b001, 3'b010: booth_add = 1'b1;
      3'b011: begin booth_shift = 1'b1; booth_add = 1'b1; end
      3'b100: begin booth_shift = 1'b1; booth_sub = 1'b1; end
      3'b101, 3'b110: booth_sub = 1'b1;
      default: begin end
    endcase
    if (force_illegal) begin
      booth_add = 1'b1;
      booth_sub = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Run one multiply; optionally re-pulse start at edge restart_at and
  // force an illegal decoder control for the cycle sampled at edge illegal_at.
  task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_exc,
                         input int restart_at, input int illegal_at);
    int n;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = ~a;
    data_operandB = ~b;
    check_eq({tag, " rdy_e0"}, {31'd0, data_resultRDY}, 32'd0);
    n = 0;
    while (!data_resultRDY && n < 40) begin
      if (n == restart_at - 1) ctrl_MULT = 1'b1;
      if (n == restart_at) ctrl_MULT = 1'b0;
      if (n == illegal_at - 1) force_illegal = 1'b1;
      if (n == illegal_at) force_illegal = 1'b0;
      @(posedge clock);
      n++;
      @(negedge clock);
    end
    ctrl_MULT     = 1'b0;
    force_illegal = 1'b0;
    check_eq({tag, " latency"}, n, 32'd16);
    check_eq({tag, " result"}, data_result, exp_res);
    check_eq({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
    @(negedge clock);
    check_eq({tag, " rdy_one_cycle"}, {31'd0, data_resultRDY}, 32'd0);
    check_eq({tag, " window_idle"}, {29'd0, booth_window}, 32'd0);
    check_eq({tag, " result_hold"}, data_result, exp_res);
  endtask

  initial begin
    int seen;
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    force_illegal = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("reset result", data_result, 32'd0);
    check_eq("reset exception", {31'd0, data_exception}, 32'd0);
    check_eq("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    check_eq("reset window", {29'd0, booth_window}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    do_mult("3x5",      32'd3,          32'd5,          32'h0000000F, 1'b0, -10, -10);
    do_mult("m7x6",     32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6, 1'b0, -10, -10);
    do_mult("maxx1",    32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF, 1'b0, -10, -10);
    do_mult("minxm1",   32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1, -10, -10);
    do_mult("2p16sq",   32'd65536,      32'd65536,      32'h00000000, 1'b1, -10, -10);
    // 1234 * -5678 = -7006652 = 0xFF951644
    do_mult("restart",  32'd1234,       32'hFFFFE9D2,   32'hFF951644, 1'b0, 5, -10);
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    check_eq("restart no_second_rdy", seen, 32'd0);

    // Reset in the middle of RUN.
    @(negedge clock);
    data_operandA = 32'd5;
    data_operandB = 32'd7;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst result", data_result, 32'd0);
    check_eq("midrst exception", {31'd0, data_exception}, 32'd0);
    check_eq("midrst rdy", {31'd0, data_resultRDY}, 32'd0);
    check_eq("midrst window", {29'd0, booth_window}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    check_eq("midrst no_rdy", seen, 32'd0);
    do_mult("2xm3",     32'd2,          32'hFFFFFFFD,   32'hFFFFFFFA, 1'b0, -10, -10);

    do_mult("illegal",  32'd4,          32'd4,          32'h00000010, 1'b1, -10, 4);
    do_mult("m1xm1",    32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 1'b0, -10, -10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
